// File: rtl/varredura_painel_if.sv
// Buffer write bus for the scrolling LED matrix scanner.
// The host side (master) drives one column pattern per write strobe; the
// scanner (slave) stores it into its message buffer.
interface varredura_painel_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [6:0]    wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/varredura_painel.sv
// Column-multiplexed scanner for a 7-row LED matrix with a scrolling message.
// A column counter walks the NCOL columns on each tick_demux strobe; the row
// pattern for the driven column is read from a NBUF-deep message buffer at
// (offset + col). Scroll requests from tick_ru are parked in a pending flag
// and only applied when the column counter wraps, so a frame is never drawn
// with two different offsets.
module varredura_painel #(
  parameter int NCOL = 5,
  parameter int NBUF = 16   // must be a power of two so the address sum wraps for free
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_demux,
  input  logic                     tick_ru,
  input  logic                     enable,
  input  logic                     scroll_en,
  varredura_painel_if.slave        wr_bus,
  output logic [NCOL-1:0]          col_sel,
  output logic [6:0]               row_data,
  output logic                     frame_done,
  output logic [$clog2(NBUF)-1:0]  offset
);

  localparam int AW = $clog2(NBUF);
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(NCOL - 1);
  localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Buffer address for a column at a given offset; the sum simply drops its
  // carry so the message wraps around the buffer.
  function automatic logic [AW-1:0] addr_f(input logic [AW-1:0] off,
                                           input logic [CW-1:0] col);
    addr_f = off + AW'(col);
  endfunction

  // One-hot column drive for a column index.
  function automatic logic [NCOL-1:0] onehot_f(input logic [CW-1:0] col);
    onehot_f = {{(NCOL-1){1'b0}}, 1'b1} << col;
  endfunction

  // Message buffer (no reset: contents survive a reset)
  logic [6:0]      mem_r [NBUF];

  // Control state
  logic [0:0]      state_r;
  logic [CW-1:0]   col_r;
  logic [AW-1:0]   offset_r;
  logic            pending_r;

  // Registered outputs
  logic [NCOL-1:0] col_sel_r;
  logic [6:0]      row_data_r;
  logic            frame_done_r;

  // Next-state values
  logic [0:0]      state_nxt_s;
  logic [CW-1:0]   col_nxt_s;
  logic [AW-1:0]   offset_nxt_s;
  logic            pending_nxt_s;
  logic            frame_done_nxt_s;
  logic            drive_s;
  logic            scroll_req_s;
  logic [AW-1:0]   rd_addr_s;
  logic [NCOL-1:0] col_sel_nxt_s;
  logic [6:0]      row_data_nxt_s;

  // Scan/blank state machine, column walk and scroll scheduling
  always_comb begin
    state_nxt_s      = state_r;
    col_nxt_s        = col_r;
    offset_nxt_s     = offset_r;
    pending_nxt_s    = pending_r;
    frame_done_nxt_s = 1'b0;
    drive_s          = 1'b0;
    scroll_req_s     = pending_r | (tick_ru & scroll_en);

    case (state_r)
      ST_IDLE: begin
        // Blanked: column parked at 0, offset and pending frozen.
        col_nxt_s = COL_ZERO;
        if (enable) begin
          state_nxt_s = ST_SCAN;
          drive_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SCAN: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
          col_nxt_s   = COL_ZERO;
        end else begin
          drive_s       = 1'b1;
          pending_nxt_s = scroll_req_s;
          if (tick_demux) begin
            if (col_r == COL_LAST) begin
              // Frame boundary: the only place the offset may move.
              col_nxt_s        = COL_ZERO;
              frame_done_nxt_s = 1'b1;
              if (scroll_req_s) begin
                offset_nxt_s  = offset_r + {{(AW-1){1'b0}}, 1'b1};
                pending_nxt_s = 1'b0;
              end else begin
                offset_nxt_s  = offset_r;
              end
            end else begin
              col_nxt_s = col_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            col_nxt_s = col_r;
          end
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        col_nxt_s   = COL_ZERO;
      end
    endcase
  end

  // Output pattern for the column about to be driven; the buffer read uses
  // the pre-write contents, so a same-cycle write shows up one cycle later.
  always_comb begin
    rd_addr_s = addr_f(offset_nxt_s, col_nxt_s);
    if (drive_s) begin
      col_sel_nxt_s  = onehot_f(col_nxt_s);
      row_data_nxt_s = mem_r[rd_addr_s];
    end else begin
      col_sel_nxt_s  = {NCOL{1'b0}};
      row_data_nxt_s = 7'h00;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      col_r        <= COL_ZERO;
      offset_r     <= {AW{1'b0}};
      pending_r    <= 1'b0;
      col_sel_r    <= {NCOL{1'b0}};
      row_data_r   <= 7'h00;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      col_r        <= col_nxt_s;
      offset_r     <= offset_nxt_s;
      pending_r    <= pending_nxt_s;
      col_sel_r    <= col_sel_nxt_s;
      row_data_r   <= row_data_nxt_s;
      frame_done_r <= frame_done_nxt_s;
    end
  end

  // Message buffer write port; writes are blocked while reset is asserted
  always_ff @(posedge clk) begin
    if (!reset && wr_bus.wr_en) begin
      mem_r[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  assign col_sel    = col_sel_r;
  assign row_data   = row_data_r;
  assign frame_done = frame_done_r;
  assign offset     = offset_r;

endmodule

// File: tb/tb_varredura_painel.sv
// Directed bench for the LED matrix scanner: column walk, scroll scheduling
// at frame wrap, blanking, buffer write hazards and mid-scan reset.
module tb_varredura_painel;

  localparam int NCOL = 5;
  localparam int NBUF = 16;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            tick_demux;
  logic            tick_ru;
  logic            enable;
  logic            scroll_en;
  logic [NCOL-1:0] col_sel;
  logic [6:0]      row_data;
  logic            frame_done;
  logic [AW-1:0]   offset;

  varredura_painel_if #(.AW(AW)) wif ();

  varredura_painel #(.NCOL(NCOL), .NBUF(NBUF)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_demux (tick_demux),
    .tick_ru    (tick_ru),
    .enable     (enable),
    .scroll_en  (scroll_en),
    .wr_bus     (wif.slave),
    .col_sel    (col_sel),
    .row_data   (row_data),
    .frame_done (frame_done),
    .offset     (offset)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         m_col;
  int         m_off;
  logic [6:0] exp_mem [NBUF];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_col();
    tick_demux = 1'b1;
    step();
    tick_demux = 1'b0;
    m_col = (m_col + 1) % NCOL;
  endtask

  task automatic ru_pulse();
    tick_ru = 1'b1;
    step();
    tick_ru = 1'b0;
  endtask

  task automatic check_disp(input string tag);
    chk({tag, ".sel"}, 32'(col_sel), 32'(1 << m_col));
    chk({tag, ".row"}, 32'(row_data), 32'(exp_mem[(m_off + m_col) % NBUF]));
    chk({tag, ".off"}, 32'(offset), 32'(m_off));
  endtask

  task automatic check_blank(input string tag);
    chk({tag, ".sel"}, 32'(col_sel), 32'h0);
    chk({tag, ".row"}, 32'(row_data), 32'h0);
    chk({tag, ".fd"},  32'(frame_done), 32'h0);
  endtask

  initial begin
    exp_mem = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h03,
                7'h05, 7'h06, 7'h09, 7'h0A, 7'h0C, 7'h11, 7'h12, 7'h7F};
    reset = 1'b1; tick_demux = 1'b0; tick_ru = 1'b0; enable = 1'b0; scroll_en = 1'b0;
    wif.wr_en = 1'b0; wif.wr_addr = '0; wif.wr_data = 7'h00;
    m_col = 0; m_off = 0;

    // Reset state
    step(); step();
    check_blank("rst");
    chk("rst.off", 32'(offset), 32'h0);
    reset = 1'b0;

    // Load the whole message while blanked
    for (int i = 0; i < NBUF; i++) begin
      wif.wr_en = 1'b1; wif.wr_addr = AW'(i); wif.wr_data = exp_mem[i];
      step();
    end
    wif.wr_en = 1'b0;
    check_blank("idle");

    // Enable: column 0 right away, then walk 5 columns; scroll_en=0 ignores tick_ru
    enable = 1'b1;
    step();
    check_disp("start");
    chk("start.fd", 32'(frame_done), 32'h0);
    for (int k = 1; k <= NCOL; k++) begin
      if (k == 2) ru_pulse();
      tick_col();
      check_disp("walk");
      chk("walk.fd", 32'(frame_done), (k == NCOL) ? 32'h1 : 32'h0);
    end
    step();
    chk("fd_one_cycle", 32'(frame_done), 32'h0);
    check_disp("hold");

    // Scroll request at column 2 waits for the wrap
    scroll_en = 1'b1;
    tick_col(); tick_col();
    ru_pulse();
    chk("scr.wait0", 32'(offset), 32'h0);
    tick_col(); tick_col();
    chk("scr.wait1", 32'(offset), 32'h0);
    tick_col();
    m_off = 1;
    chk("scr.off", 32'(offset), 32'h1);
    chk("scr.row", 32'(row_data), 32'h02);
    chk("scr.sel", 32'(col_sel), 32'h01);
    chk("scr.fd",  32'(frame_done), 32'h1);

    // Three requests in one frame give a single step
    ru_pulse(); tick_col();
    ru_pulse(); tick_col(); tick_col();
    ru_pulse(); tick_col();
    chk("multi.wait", 32'(offset), 32'h1);
    tick_col();
    m_off = 2;
    check_disp("multi");
    for (int k = 0; k < NCOL; k++) tick_col();
    check_disp("noscroll");

    // Request coincident with the wrapping tick is applied at that wrap
    for (int k = 0; k < NCOL - 1; k++) tick_col();
    tick_demux = 1'b1; tick_ru = 1'b1;
    step();
    tick_demux = 1'b0; tick_ru = 1'b0;
    m_col = 0; m_off = 3;
    check_disp("coinc");

    // Walk offset up to 15, then wrap it to 0
    while (m_off < NBUF - 1) begin
      for (int k = 0; k < NCOL - 1; k++) tick_col();
      tick_demux = 1'b1; tick_ru = 1'b1;
      step();
      tick_demux = 1'b0; tick_ru = 1'b0;
      m_col = 0; m_off++;
      chk("climb.off", 32'(offset), 32'(m_off));
    end
    tick_col();
    chk("off15.row_wrap", 32'(row_data), 32'h01);
    ru_pulse();
    tick_col(); tick_col(); tick_col();
    chk("off15.wait", 32'(offset), 32'hF);
    tick_col();
    m_off = 0;
    chk("offwrap.off", 32'(offset), 32'h0);
    for (int k = 0; k < NCOL - 1; k++) tick_col();
    chk("offwrap.col4", 32'(row_data), 32'h10);

    // Write to the address being shown: old value this cycle, new one next
    wif.wr_en = 1'b1; wif.wr_addr = AW'(4); wif.wr_data = 7'h2A;
    step();
    wif.wr_en = 1'b0;
    chk("wr.old", 32'(row_data), 32'h10);
    step();
    chk("wr.new", 32'(row_data), 32'h2A);
    exp_mem[4] = 7'h2A;

    // Blank at column 3 with a pending scroll; pending survives IDLE
    tick_col();
    tick_col(); tick_col(); tick_col();
    ru_pulse();
    enable = 1'b0;
    step();
    check_blank("off");
    chk("off.off", 32'(offset), 32'h0);
    step(); step(); step();
    check_blank("off2");
    chk("off2.off", 32'(offset), 32'h0);
    enable = 1'b1;
    step();
    m_col = 0;
    check_disp("reen");
    for (int k = 0; k < NCOL; k++) tick_col();
    m_off = 1;
    check_disp("reen.wrap");

    // Reset at column 2 with pending set; write during reset is blocked
    tick_col(); tick_col();
    ru_pulse();
    reset = 1'b1;
    wif.wr_en = 1'b1; wif.wr_addr = AW'(0); wif.wr_data = 7'h7E;
    step();
    reset = 1'b0;
    wif.wr_en = 1'b0;
    check_blank("midrst");
    chk("midrst.off", 32'(offset), 32'h0);
    step();
    m_col = 0; m_off = 0;
    check_disp("postrst");
    chk("postrst.row0", 32'(row_data), 32'h01);
    for (int k = 0; k < NCOL; k++) tick_col();
    chk("postrst.off", 32'(offset), 32'h0);
    chk("postrst.fd",  32'(frame_done), 32'h1);
    check_disp("postrst.wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
